// File: rtl/frame_sync_ctrl.sv
// Frame-level sequencer for the TMDS pixel domain: waits for video packets, runs the
// front-porch delay, then scans one frame of h/v timing with aligned sync/DE outputs.
module frame_sync_ctrl #(
    parameter int H_TOTAL       = 1650,
    parameter int H_ACTIVE      = 1280,
    parameter int H_SYNC_START  = 1390,
    parameter int H_SYNC_END    = 1430,
    parameter int V_ACTIVE      = 720,
    parameter int FP_CYCLES     = 33000,
    parameter int EMPTY_TIMEOUT = 4950
) (
    input  logic        tmds_clk,
    input  logic        sys_rst_n,
    input  logic        pkt_valid,
    input  logic        fifo_empty,
    output logic [11:0] h_count,
    output logic [11:0] v_count,
    output logic        restart,
    output logic        fifo_rst,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [15:0] frame_cnt,
    output logic        timeout
);

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT_W    = 12'(H_ACTIVE);
    localparam logic [11:0] HS_START_W = 12'(H_SYNC_START);
    localparam logic [11:0] HS_END_W   = 12'(H_SYNC_END);
    localparam logic [11:0] V_ACT_W    = 12'(V_ACTIVE);
    localparam logic [15:0] FP_LAST    = 16'(FP_CYCLES - 1);
    localparam logic [12:0] ET_LAST    = 13'(EMPTY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FPORCH = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_VWAIT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] fp_cnt_q, fp_cnt_d;
    logic [12:0] empty_cnt_q, empty_cnt_d;
    logic [11:0] h_q, h_d;
    logic [11:0] v_q, v_d;
    logic [15:0] frame_q, frame_d;
    logic        timeout_q, timeout_d;
    logic        restart_q, restart_d;
    logic        fifo_rst_q, fifo_rst_d;

    logic        de_int_s, hs_int_s, vs_int_s;
    logic        de_p_q, hs_p_q, vs_p_q;
    logic        de_q, hs_q, vs_q;

    // Next-state, counter and sticky-flag logic for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        fp_cnt_d    = fp_cnt_q;
        empty_cnt_d = empty_cnt_q;
        h_d         = h_q;
        v_d         = v_q;
        frame_d     = frame_q;
        timeout_d   = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (pkt_valid) begin
                    state_d  = ST_FPORCH;
                    fp_cnt_d = 16'd0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_FPORCH: begin
                if (fp_cnt_q == FP_LAST) begin
                    state_d = ST_ACTIVE;
                    h_d     = 12'd0;
                    v_d     = 12'd0;
                end else begin
                    fp_cnt_d = fp_cnt_q + 16'd1;
                end
            end
            ST_ACTIVE: begin
                if (h_q == H_LAST) begin
                    h_d = 12'd0;
                    v_d = v_q + 12'd1;
                    if ((v_q + 12'd1) == V_ACT_W) begin
                        state_d     = ST_VWAIT;
                        frame_d     = frame_q + 16'd1;
                        empty_cnt_d = 13'd0;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end else begin
                    h_d = h_q + 12'd1;
                end
            end
            ST_VWAIT: begin
                // A new packet wins over an expiring empty timeout in the same cycle.
                if (pkt_valid) begin
                    state_d     = ST_FPORCH;
                    fp_cnt_d    = 16'd0;
                    empty_cnt_d = 13'd0;
                end else if (fifo_empty) begin
                    if (empty_cnt_q == ET_LAST) begin
                        state_d     = ST_IDLE;
                        timeout_d   = 1'b1;
                        empty_cnt_d = 13'd0;
                    end else begin
                        empty_cnt_d = empty_cnt_q + 13'd1;
                    end
                end else begin
                    empty_cnt_d = 13'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        restart_d  = (state_d == ST_FPORCH) && (fp_cnt_d == FP_LAST);
        fifo_rst_d = (state_d == ST_IDLE) || (state_d == ST_VWAIT);
    end

    // Sequencer state and counter registers.
    always_ff @(posedge tmds_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            fp_cnt_q    <= 16'd0;
            empty_cnt_q <= 13'd0;
            h_q         <= 12'd0;
            v_q         <= 12'd0;
            frame_q     <= 16'd0;
            timeout_q   <= 1'b0;
            restart_q   <= 1'b0;
            fifo_rst_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            fp_cnt_q    <= fp_cnt_d;
            empty_cnt_q <= empty_cnt_d;
            h_q         <= h_d;
            v_q         <= v_d;
            frame_q     <= frame_d;
            timeout_q   <= timeout_d;
            restart_q   <= restart_d;
            fifo_rst_q  <= fifo_rst_d;
        end
    end

    // Raw video timing decode from the current state and counters.
    always_comb begin
        de_int_s = 1'b0;
        hs_int_s = 1'b0;
        vs_int_s = 1'b0;
        if (state_q == ST_ACTIVE) begin
            de_int_s = (h_q < H_ACT_W) && (v_q < V_ACT_W);
            hs_int_s = (h_q >= HS_START_W) && (h_q < HS_END_W);
        end else begin
            vs_int_s = (state_q == ST_VWAIT);
        end
    end

    // Two-stage pipeline keeps DE, HSYNC and VSYNC mutually aligned at the encoder.
    always_ff @(posedge tmds_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            de_p_q <= 1'b0;
            hs_p_q <= 1'b0;
            vs_p_q <= 1'b0;
            de_q   <= 1'b0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
        end else begin
            de_p_q <= de_int_s;
            hs_p_q <= hs_int_s;
            vs_p_q <= vs_int_s;
            de_q   <= de_p_q;
            hs_q   <= hs_p_q;
            vs_q   <= vs_p_q;
        end
    end

    assign h_count   = h_q;
    assign v_count   = v_q;
    assign restart   = restart_q;
    assign fifo_rst  = fifo_rst_q;
    assign hsync     = hs_q;
    assign vsync     = vs_q;
    assign de        = de_q;
    assign frame_cnt = frame_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Directed bench for frame_sync_ctrl; timing parameters are scaled down so complete
// frames, front porches and empty timeouts fit in a short run.
module tb_frame_sync_ctrl;

    localparam int HT  = 40;
    localparam int HA  = 24;
    localparam int HSS = 28;
    localparam int HSE = 32;
    localparam int VA  = 6;
    localparam int FP  = 300;
    localparam int ET  = 50;

    logic        tmds_clk = 1'b0;
    logic        sys_rst_n;
    logic        pkt_valid;
    logic        fifo_empty;
    logic [11:0] h_count;
    logic [11:0] v_count;
    logic        restart;
    logic        fifo_rst;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [15:0] frame_cnt;
    logic        timeout;

    int n_vec = 0;
    int n_err = 0;

    frame_sync_ctrl #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_ACTIVE(VA), .FP_CYCLES(FP), .EMPTY_TIMEOUT(ET)
    ) dut (
        .tmds_clk(tmds_clk), .sys_rst_n(sys_rst_n), .pkt_valid(pkt_valid),
        .fifo_empty(fifo_empty), .h_count(h_count), .v_count(v_count),
        .restart(restart), .fifo_rst(fifo_rst), .hsync(hsync), .vsync(vsync),
        .de(de), .frame_cnt(frame_cnt), .timeout(timeout)
    );

    always #5 tmds_clk = ~tmds_clk;

    task automatic step();
        @(posedge tmds_clk);
        #1;
    endtask

    task automatic test_reset();
        int bad;
        sys_rst_n  = 1'b0;
        pkt_valid  = 1'b0;
        fifo_empty = 1'b1;
        repeat (3) step();
        n_vec++; if (fifo_rst !== 1'b1) begin n_err++; $display("FAIL reset_fifo_rst: got %b want 1", fifo_rst); end
        n_vec++; if ({de, hsync, vsync, restart, timeout} !== 5'b00000) begin n_err++; $display("FAIL reset_flags: got %b want 00000", {de, hsync, vsync, restart, timeout}); end
        n_vec++; if ({h_count, v_count, frame_cnt} !== 40'd0) begin n_err++; $display("FAIL reset_counters: got h=%0d v=%0d f=%0d want 0", h_count, v_count, frame_cnt); end
        sys_rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (restart || !fifo_rst || de || hsync || vsync || timeout || frame_cnt != 16'd0) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL idle_hold: got %0d bad cycles want 0", bad); end
    endtask

    // Leaves the bench at the first ACTIVE cycle (h_count=0).
    task automatic test_fporch(input bit exp_timeout);
        int rs_cnt;
        int rs_at;
        pkt_valid = 1'b1;
        step();
        pkt_valid = 1'b0;
        n_vec++; if (fifo_rst !== 1'b0) begin n_err++; $display("FAIL fp_fifo_rst: got %b want 0", fifo_rst); end
        n_vec++; if (restart !== 1'b0) begin n_err++; $display("FAIL fp_early_restart: got %b want 0", restart); end
        rs_cnt = 0;
        rs_at  = -1;
        for (int k = 1; k < FP; k++) begin
            pkt_valid = (k == FP / 2);
            step();
            if (restart) begin rs_cnt++; rs_at = k; end
        end
        pkt_valid = 1'b0;
        n_vec++; if (rs_cnt != 1 || rs_at != FP - 1) begin n_err++; $display("FAIL fp_restart_time: got count=%0d at=%0d want count=1 at=%0d", rs_cnt, rs_at, FP - 1); end
        n_vec++; if (timeout !== exp_timeout) begin n_err++; $display("FAIL fp_timeout: got %b want %b", timeout, exp_timeout); end
        step();
        n_vec++; if ({restart, de, h_count, v_count} !== 26'd0) begin n_err++; $display("FAIL active_entry: got rs=%b de=%b h=%0d v=%0d want all 0", restart, de, h_count, v_count); end
    endtask

    // Starts at the first ACTIVE cycle, ends a few cycles into VWAIT.
    task automatic test_frame(input int frame_no);
        int err_hv, err_de, err_hs, err_vs, err_rs, de_total, p;
        logic [11:0] exp_h, exp_v;
        logic de_e, hs_e, vs_e;
        fifo_empty = 1'b0;
        err_hv = 0; err_de = 0; err_hs = 0; err_vs = 0; err_rs = 0; de_total = 0;
        for (int c = 0; c <= VA * HT + 3; c++) begin
            if (c > 0) step();
            exp_h = (c < VA * HT) ? 12'(c % HT) : 12'd0;
            exp_v = (c < VA * HT) ? 12'(c / HT) : 12'(VA);
            p     = c - 2;
            de_e  = (p >= 0) && (p < VA * HT) && ((p % HT) < HA);
            hs_e  = (p >= 0) && (p < VA * HT) && ((p % HT) >= HSS) && ((p % HT) < HSE);
            vs_e  = (p >= VA * HT);
            if (h_count !== exp_h || v_count !== exp_v) err_hv++;
            if (de !== de_e) err_de++;
            if (hsync !== hs_e) err_hs++;
            if (vsync !== vs_e) err_vs++;
            if (restart !== 1'b0) err_rs++;
            if (de === 1'b1) de_total++;
        end
        n_vec++; if (err_hv != 0) begin n_err++; $display("FAIL frame_hv: got %0d bad cycles want 0", err_hv); end
        n_vec++; if (err_de != 0) begin n_err++; $display("FAIL frame_de: got %0d bad cycles want 0", err_de); end
        n_vec++; if (err_hs != 0) begin n_err++; $display("FAIL frame_hsync: got %0d bad cycles want 0", err_hs); end
        n_vec++; if (err_vs != 0) begin n_err++; $display("FAIL frame_vsync: got %0d bad cycles want 0", err_vs); end
        n_vec++; if (err_rs != 0) begin n_err++; $display("FAIL frame_restart: got %0d bad cycles want 0", err_rs); end
        n_vec++; if (de_total != VA * HA) begin n_err++; $display("FAIL frame_de_total: got %0d want %0d", de_total, VA * HA); end
        n_vec++; if (frame_cnt !== 16'(frame_no)) begin n_err++; $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, frame_no); end
        n_vec++; if (fifo_rst !== 1'b1) begin n_err++; $display("FAIL vwait_fifo_rst: got %b want 1", fifo_rst); end
    endtask

    task automatic test_pkt_priority();
        fifo_empty = 1'b1;
        repeat (ET - 1) step();
        n_vec++; if ({timeout, fifo_rst} !== 2'b01) begin n_err++; $display("FAIL prio_pre: got to=%b fr=%b want to=0 fr=1", timeout, fifo_rst); end
        pkt_valid = 1'b1;
        step();
        pkt_valid = 1'b0;
        n_vec++; if ({timeout, fifo_rst} !== 2'b00) begin n_err++; $display("FAIL prio_take: got to=%b fr=%b want to=0 fr=0", timeout, fifo_rst); end
        repeat (FP - 1) step();
        n_vec++; if (restart !== 1'b1) begin n_err++; $display("FAIL prio_restart: got %b want 1", restart); end
        step();
        n_vec++; if ({h_count, v_count} !== 24'd0) begin n_err++; $display("FAIL prio_active: got h=%0d v=%0d want 0", h_count, v_count); end
    endtask

    task automatic test_timeout();
        fifo_empty = 1'b1;
        repeat (20) step();
        fifo_empty = 1'b0;
        step();
        fifo_empty = 1'b1;
        repeat (ET - 1) step();
        n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL to_early: got %b want 0", timeout); end
        step();
        n_vec++; if ({timeout, fifo_rst} !== 2'b11) begin n_err++; $display("FAIL to_fire: got to=%b fr=%b want 11", timeout, fifo_rst); end
        repeat (3) step();
        n_vec++; if ({timeout, vsync} !== 2'b10) begin n_err++; $display("FAIL to_idle: got to=%b vs=%b want to=1 vs=0", timeout, vsync); end
        n_vec++; if (frame_cnt !== 16'd2) begin n_err++; $display("FAIL to_frame_cnt: got %0d want 2", frame_cnt); end
    endtask

    task automatic test_mid_reset();
        int bad;
        repeat (3 * HT + 5) step();
        n_vec++; if ({v_count, h_count, de} !== {12'd3, 12'd5, 1'b1}) begin n_err++; $display("FAIL mid_pre: got v=%0d h=%0d de=%b want v=3 h=5 de=1", v_count, h_count, de); end
        sys_rst_n = 1'b0;
        #2;
        n_vec++; if ({h_count, v_count, frame_cnt} !== 40'd0) begin n_err++; $display("FAIL mid_counters: got h=%0d v=%0d f=%0d want 0", h_count, v_count, frame_cnt); end
        n_vec++; if ({fifo_rst, de, hsync, vsync, restart, timeout} !== 6'b100000) begin n_err++; $display("FAIL mid_flags: got %b want 100000", {fifo_rst, de, hsync, vsync, restart, timeout}); end
        step();
        sys_rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 2 * FP; i++) begin
            step();
            if (restart || !fifo_rst) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL mid_no_restart: got %0d bad cycles want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_fporch(1'b0);
        test_frame(1);
        test_pkt_priority();
        test_frame(2);
        test_timeout();
        test_fporch(1'b1);
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
